jtcop_objdma: RTL and testbench

JTCOP_OBJDMA -- requirements
Module: jtcop_objdma

---
 rtl/jtcop_pkg.sv | 22 ++
 rtl/jtcop_objdma.sv | 133 +++++++++++++
 tb/tb_jtcop_objdma.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtcop_pkg.sv
// Shared definitions for the object DMA and the object renderer that reads
// the buffer it fills.
package jtcop_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        COPY = 3'd3,
        DONE = 3'd4
    } objdma_state_t;

    // Default object RAM geometry: 2**10 words of 16 bits.
    localparam int OBJDMA_AW    = 10;
    localparam int OBJDMA_WORDS = 1 << OBJDMA_AW;

    // Number of words moved by one copy for a given address width.
    function automatic int objdma_words(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/jtcop_objdma.sv
// Object DMA: on an obj_copy strobe it requests the CPU bus, waits for the
// grant with the address strobe released, then copies the whole object RAM
// into the object buffer, one word per cen tick.
//
// Bus handshake: BRn goes low with the request; the copy starts only on a
// cen tick that sees BGn=0 and ASn=1 together, at which point BGACKn is
// asserted and BRn released. BGACKn is held low until the last word has
// been written, whatever BGn does meanwhile.
module jtcop_objdma
    import jtcop_pkg::*;
#(
    parameter int AW = OBJDMA_AW
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          obj_copy,
    input  logic          ASn,
    input  logic          BGn,
    output logic          BRn,
    output logic          BGACKn,
    output logic          busy,
    output logic [AW-1:0] src_addr,
    input  logic [15:0]   src_dout,
    output logic [AW-1:0] dst_addr,
    output logic [15:0]   dst_din,
    output logic          dst_we,
    output objdma_state_t dbg_state
);

    // One extra bit so the count can reach the word total without wrapping.
    localparam logic [AW:0] WORDS = (AW+1)'(objdma_words(AW));

    objdma_state_t st, st_nxt;
    logic          obj_copy_l;
    logic          pending;
    logic          rd_valid;   // src_dout holds data for the previous address
    logic          we_r;
    logic [AW:0]   cnt;        // words written so far in this copy
    logic          req;

    assign req       = cen & obj_copy & ~obj_copy_l;
    assign dst_we    = we_r & cen;
    assign dbg_state = st;

    // Next-state decode.
    always_comb begin
        st_nxt = st;
        case (st)
            IDLE:    if (req) st_nxt = REQ;
            REQ:     if (!obj_copy) st_nxt = WAIT;
            WAIT:    if (!BGn && ASn) st_nxt = COPY;
            COPY:    if (cnt == WORDS) st_nxt = DONE;
            DONE:    st_nxt = pending ? REQ : IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)      st <= IDLE;
        else if (cen) st <= st_nxt;
    end

    // Bus signals, request tracking and the copy datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            obj_copy_l <= 1'b1;   // a strobe already high at release is no edge
            pending    <= 1'b0;
            rd_valid   <= 1'b0;
            we_r       <= 1'b0;
            cnt        <= '0;
            BRn        <= 1'b1;
            BGACKn     <= 1'b1;
            busy       <= 1'b0;
            src_addr   <= '0;
            dst_addr   <= '0;
            dst_din    <= '0;
        end else if (cen) begin
            obj_copy_l <= obj_copy;
            we_r       <= 1'b0;

            if (st == DONE)
                pending <= 1'b0;
            else if (req && (st == REQ || st == WAIT || st == COPY))
                pending <= 1'b1;

            case (st)
                IDLE: begin
                    if (st_nxt == REQ) begin
                        BRn  <= 1'b0;
                        busy <= 1'b1;
                    end
                end
                WAIT: begin
                    if (st_nxt == COPY) begin
                        BRn      <= 1'b1;
                        BGACKn   <= 1'b0;
                        cnt      <= '0;
                        src_addr <= '0;
                        rd_valid <= 1'b0;
                    end
                end
                COPY: begin
                    if (st_nxt == DONE) begin
                        BGACKn <= 1'b1;
                        // Stay busy when another copy is already queued.
                        busy   <= pending | req;
                    end else begin
                        src_addr <= src_addr + 1'b1;
                        rd_valid <= 1'b1;
                        if (rd_valid) begin
                            we_r     <= 1'b1;
                            dst_addr <= cnt[AW-1:0];
                            dst_din  <= src_dout;
                            cnt      <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (st_nxt == REQ) begin
                        BRn  <= 1'b0;
                        busy <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jtcop_objdma.sv
// Directed bench for jtcop_objdma with AW=4: a synchronous source RAM model,
// a write log of the object buffer port, and one task per scenario.
module tb_jtcop_objdma;
  import jtcop_pkg::*;

  localparam int AW = 4;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          rst, cen, obj_copy, ASn, BGn;
  logic          BRn, BGACKn, busy, dst_we;
  logic [AW-1:0] src_addr, dst_addr;
  logic [15:0]   src_dout, dst_din;
  objdma_state_t dbg_state;

  logic [15:0]   src_mem [NW];
  logic [AW-1:0] wr_addr_q[$];
  logic [15:0]   wr_data_q[$];
  logic [15:0]   exp_q[$];
  int            bad_we;
  int            n_checks = 0;
  int            n_errors = 0;

  jtcop_objdma #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .cen(cen), .obj_copy(obj_copy), .ASn(ASn), .BGn(BGn),
    .BRn(BRn), .BGACKn(BGACKn), .busy(busy), .src_addr(src_addr), .src_dout(src_dout),
    .dst_addr(dst_addr), .dst_din(dst_din), .dst_we(dst_we), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // source RAM (data one cen tick after address) and buffer write monitor
  always @(posedge clk) begin
    if (cen) src_dout <= src_mem[src_addr];
    if (dst_we) begin
      wr_addr_q.push_back(dst_addr);
      wr_data_q.push_back(dst_din);
    end
    if (dst_we && !cen) bad_we++;
  end

  // driver tasks
  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    exp_q.delete();
    bad_we = 0;
  endtask

  task automatic request_copy();
    @(negedge clk); obj_copy = 1'b1;
    repeat (3) @(negedge clk);
    obj_copy = 1'b0;
  endtask

  task automatic wait_state(input objdma_state_t s, input int limit, output bit ok);
    int n;
    n = 0;
    while (dbg_state != s && n < limit) begin
      @(negedge clk); n++;
    end
    ok = (dbg_state == s);
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1; cen = 1'b0; obj_copy = 1'b0; ASn = 1'b1; BGn = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (BRn !== 1'b1) begin n_errors++; $display("FAIL reset_brn: got %b want 1", BRn); end
    n_checks++; if (BGACKn !== 1'b1) begin n_errors++; $display("FAIL reset_bgackn: got %b want 1", BGACKn); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (dst_we !== 1'b0) begin n_errors++; $display("FAIL reset_we: got %b want 0", dst_we); end
    n_checks++; if (src_addr !== 4'd0) begin n_errors++; $display("FAIL reset_src_addr: got %0h want 0", src_addr); end
    n_checks++; if (dst_addr !== 4'd0) begin n_errors++; $display("FAIL reset_dst_addr: got %0h want 0", dst_addr); end
    n_checks++; if (dst_din !== 16'd0) begin n_errors++; $display("FAIL reset_dst_din: got %0h want 0", dst_din); end
    n_checks++; if (dbg_state !== IDLE) begin n_errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
    rst = 1'b0; cen = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    int n;
    clear_logs();
    for (int i = 0; i < NW; i++) exp_q.push_back(src_mem[i]);
    @(negedge clk); obj_copy = 1'b1;
    @(negedge clk);
    n_checks++; if (BRn !== 1'b0) begin n_errors++; $display("FAIL basic_brn_fall: got %b want 0", BRn); end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL basic_busy_set: got %b want 1", busy); end
    // grant offered early: must not start while the strobe is still high
    BGn = 1'b0; ASn = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (dbg_state !== REQ) begin n_errors++; $display("FAIL basic_hold_req: got %0d want %0d", dbg_state, REQ); end
    n_checks++; if (BGACKn !== 1'b1) begin n_errors++; $display("FAIL basic_no_early_dma: got %b want 1", BGACKn); end
    obj_copy = 1'b0;
    @(negedge clk);
    n_checks++; if (dbg_state !== WAIT) begin n_errors++; $display("FAIL basic_wait: got %0d want %0d", dbg_state, WAIT); end
    @(negedge clk);
    n_checks++; if (BGACKn !== 1'b0) begin n_errors++; $display("FAIL basic_bgackn: got %b want 0", BGACKn); end
    n_checks++; if (BRn !== 1'b1) begin n_errors++; $display("FAIL basic_brn_release: got %b want 1", BRn); end
    BGn = 1'b1;  // grant dropped mid-copy
    n = 0;
    while (dbg_state != DONE && n < 60) begin @(negedge clk); n++; end
    n_checks++; if (dbg_state !== DONE) begin n_errors++; $display("FAIL basic_done: got %0d want %0d", dbg_state, DONE); end
    n_checks++; if (busy !== 1'b0 || BGACKn !== 1'b1 || dst_we !== 1'b0) begin
      n_errors++; $display("FAIL basic_done_outputs: got busy=%b bgackn=%b we=%b want 0 1 0", busy, BGACKn, dst_we); end
    wait_state(IDLE, 5, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL basic_idle: got %0d want %0d", dbg_state, IDLE); end
    n_checks++; if (wr_addr_q.size() != NW) begin n_errors++; $display("FAIL basic_count: got %0d want %0d", wr_addr_q.size(), NW); end
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      n_checks++;
      if (wr_addr_q[i] !== 4'(i % NW) || wr_data_q[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL basic_word%0d: got %0h/%0h want %0h/%0h", i, wr_addr_q[i], wr_data_q[i], 4'(i % NW), exp_q[i]); end
    end
  endtask

  task automatic test_bus_wait();
    bit ok;
    clear_logs();
    for (int i = 0; i < NW; i++) exp_q.push_back(src_mem[i]);
    BGn = 1'b1; ASn = 1'b1;
    request_copy();
    repeat (2) begin
      @(negedge clk);
      n_checks++; if (dbg_state !== WAIT || BRn !== 1'b0) begin
        n_errors++; $display("FAIL wait_no_grant: got state=%0d brn=%b want %0d 0", dbg_state, BRn, WAIT); end
    end
    BGn = 1'b0; ASn = 1'b0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      n_checks++; if (dbg_state !== WAIT || BRn !== 1'b0) begin
        n_errors++; $display("FAIL wait_as_low%0d: got state=%0d brn=%b want %0d 0", t, dbg_state, BRn, WAIT); end
    end
    ASn = 1'b1;
    @(negedge clk);
    n_checks++; if (dbg_state !== COPY || BGACKn !== 1'b0) begin
      n_errors++; $display("FAIL wait_copy_start: got state=%0d bgackn=%b want %0d 0", dbg_state, BGACKn, COPY); end
    BGn = 1'b1;
    wait_state(IDLE, 60, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL wait_finish: got %0d want %0d", dbg_state, IDLE); end
    n_checks++; if (wr_addr_q.size() != NW) begin n_errors++; $display("FAIL wait_count: got %0d want %0d", wr_addr_q.size(), NW); end
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      n_checks++;
      if (wr_addr_q[i] !== 4'(i % NW) || wr_data_q[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL wait_word%0d: got %0h/%0h want %0h/%0h", i, wr_addr_q[i], wr_data_q[i], 4'(i % NW), exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int copies, drops, n;
    objdma_state_t prev;
    clear_logs();
    for (int i = 0; i < 2 * NW; i++) exp_q.push_back(src_mem[i % NW]);
    BGn = 1'b0; ASn = 1'b1;
    request_copy();
    wait_state(COPY, 10, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL b2b_first_copy: got %0d want %0d", dbg_state, COPY); end
    repeat (2) begin
      @(negedge clk); obj_copy = 1'b1;
      repeat (2) @(negedge clk);
      obj_copy = 1'b0;
      @(negedge clk);
    end
    copies = 1; drops = 0; n = 0; prev = dbg_state;
    while (dbg_state != IDLE && n < 200) begin
      @(negedge clk); n++;
      if (dbg_state == COPY && prev != COPY) copies++;
      if (busy !== 1'b1 && copies < 2) drops++;
      prev = dbg_state;
    end
    n_checks++; if (copies != 2) begin n_errors++; $display("FAIL b2b_copies: got %0d want 2", copies); end
    n_checks++; if (drops != 0) begin n_errors++; $display("FAIL b2b_busy_gap: got %0d low cycles want 0", drops); end
    repeat (30) @(negedge clk);
    n_checks++; if (dbg_state !== IDLE || busy !== 1'b0) begin
      n_errors++; $display("FAIL b2b_settle: got state=%0d busy=%b want %0d 0", dbg_state, busy, IDLE); end
    n_checks++; if (wr_addr_q.size() != 2 * NW) begin n_errors++; $display("FAIL b2b_count: got %0d want %0d", wr_addr_q.size(), 2 * NW); end
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      n_checks++;
      if (wr_addr_q[i] !== 4'(i % NW) || wr_data_q[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL b2b_word%0d: got %0h/%0h want %0h/%0h", i, wr_addr_q[i], wr_data_q[i], 4'(i % NW), exp_q[i]); end
    end
    BGn = 1'b1;
  endtask

  task automatic test_cen();
    bit ok;
    int n, hold_err;
    logic [AW-1:0] prev_src;
    clear_logs();
    for (int i = 0; i < NW; i++) exp_q.push_back(src_mem[i]);
    BGn = 1'b0; ASn = 1'b1;
    request_copy();
    wait_state(COPY, 10, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL cen_copy: got %0d want %0d", dbg_state, COPY); end
    n = 0; hold_err = 0; prev_src = src_addr;
    while (dbg_state != IDLE && n < 300) begin
      @(negedge clk); n++;
      if (cen == 1'b0 && src_addr !== prev_src) hold_err++;
      prev_src = src_addr;
      cen = ~cen;
    end
    cen = 1'b1;
    BGn = 1'b1;
    n_checks++; if (dbg_state !== IDLE) begin n_errors++; $display("FAIL cen_finish: got %0d want %0d", dbg_state, IDLE); end
    n_checks++; if (bad_we != 0) begin n_errors++; $display("FAIL cen_we_gated: got %0d writes with cen=0 want 0", bad_we); end
    n_checks++; if (hold_err != 0) begin n_errors++; $display("FAIL cen_hold: got %0d address changes with cen=0 want 0", hold_err); end
    n_checks++; if (wr_addr_q.size() != NW) begin n_errors++; $display("FAIL cen_count: got %0d want %0d", wr_addr_q.size(), NW); end
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      n_checks++;
      if (wr_addr_q[i] !== 4'(i % NW) || wr_data_q[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL cen_word%0d: got %0h/%0h want %0h/%0h", i, wr_addr_q[i], wr_data_q[i], 4'(i % NW), exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_copy();
    int n;
    clear_logs();
    BGn = 1'b0; ASn = 1'b1;
    request_copy();
    n = 0;
    while (!(dst_we === 1'b1 && dst_addr === 4'd7) && n < 60) begin @(negedge clk); n++; end
    n_checks++; if (dst_we !== 1'b1 || dst_addr !== 4'd7) begin
      n_errors++; $display("FAIL rstcopy_reach_word7: got we=%b addr=%0h want 1 7", dst_we, dst_addr); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (BRn !== 1'b1 || BGACKn !== 1'b1 || busy !== 1'b0 || dst_we !== 1'b0) begin
      n_errors++; $display("FAIL rstcopy_outputs: got brn=%b bgackn=%b busy=%b we=%b want 1 1 0 0", BRn, BGACKn, busy, dst_we); end
    n_checks++; if (dbg_state !== IDLE) begin n_errors++; $display("FAIL rstcopy_state: got %0d want %0d", dbg_state, IDLE); end
    rst = 1'b0;
    repeat (30) @(negedge clk);
    n_checks++; if (wr_addr_q.size() != 8) begin n_errors++; $display("FAIL rstcopy_no_more_writes: got %0d want 8", wr_addr_q.size()); end
    n_checks++; if (dbg_state !== IDLE || BRn !== 1'b1) begin
      n_errors++; $display("FAIL rstcopy_no_resume: got state=%0d brn=%b want %0d 1", dbg_state, BRn, IDLE); end
    BGn = 1'b1;
  endtask

  task automatic test_obj_high_reset();
    int bad;
    rst = 1'b1; obj_copy = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (BRn !== 1'b1 || dbg_state !== IDLE) bad++;
    end
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL objhigh_no_request: got %0d bad cycles want 0", bad); end
    obj_copy = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (dbg_state !== IDLE || busy !== 1'b0) begin
      n_errors++; $display("FAIL objhigh_idle: got state=%0d busy=%b want %0d 0", dbg_state, busy, IDLE); end
  endtask

  initial begin
    for (int i = 0; i < NW; i++) src_mem[i] = 16'hC0DE ^ (16'(i) * 16'h1111);
    src_dout = 16'd0;
    bad_we = 0;
    test_reset();
    test_basic();
    test_bus_wait();
    test_back_to_back();
    test_cen();
    test_reset_mid_copy();
    test_obj_high_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
